// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache.
// Holds the FSM state encoding, the default uncached (MMIO) boundary and
// helpers that split a byte address into line index and tag.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_REQ = 2'd1,
    WR_REQ = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h8000_0000;

  // Line index: word address bits just above the byte offset.
  // The caller truncates the result to its index width.
  function automatic logic [31:0] line_index(input logic [31:0] addr, input int unsigned idx_w);
    return (addr >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  // Tag: everything above the index. The caller truncates to its tag width.
  function automatic logic [31:0] line_tag(input logic [31:0] addr, input int unsigned idx_w);
    return addr >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag and data storage for dcache: one word per line, asynchronous read,
// synchronous write. Ports: i_idx selects the line for both read and write;
// o_tag/o_data are the combinational read; i_fill writes tag + full word;
// i_wr_be merges enabled bytes of i_wr_data into the line (tag untouched).
// No reset: line contents are qualified by the valid bits kept in dcache.
module dcache_array #(
  parameter int LINES = 64,
  parameter int IDX   = 6,
  parameter int TAGW  = 24
) (
  input  logic            i_clk,
  input  logic [IDX-1:0]  i_idx,
  output logic [TAGW-1:0] o_tag,
  output logic [31:0]     o_data,
  input  logic            i_fill,
  input  logic [TAGW-1:0] i_fill_tag,
  input  logic [31:0]     i_fill_data,
  input  logic [3:0]      i_wr_be,
  input  logic [31:0]     i_wr_data
);

  logic [TAGW-1:0] tag_mem  [LINES];
  logic [31:0]     data_mem [LINES];

  assign o_tag  = tag_mem[i_idx];
  assign o_data = data_mem[i_idx];

  always_ff @(posedge i_clk) begin
    if (i_fill) begin
      tag_mem[i_idx]  <= i_fill_tag;
      data_mem[i_idx] <= i_fill_data;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (i_wr_be[b]) data_mem[i_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the CPU data port.
// Ports: CPU side i_addr/i_we/i_rd/i_data in, o_data/o_valid out (o_valid low = stall);
// backing bus o_mem_req/o_mem_addr/o_mem_we/o_mem_data out, i_mem_ack/i_mem_data in.
// Load hits complete in the same cycle; misses, stores and MMIO take >= 2 cycles.
module dcache
  import dcache_pkg::*;
#(
  parameter int          LINES   = 64,
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_we,
  input  logic        i_rd,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic        o_valid,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_we,
  output logic [31:0] o_mem_data,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_data
);

  localparam int IDX  = $clog2(LINES);
  localparam int TAGW = 32 - IDX - 2;

  state_e            state_q, state_d;
  logic [LINES-1:0]  valid_q;
  logic [31:0]       resp_q;

  logic [IDX-1:0]    idx;
  logic [TAGW-1:0]   tag;
  logic [TAGW-1:0]   arr_tag;
  logic [31:0]       arr_data;
  logic              cacheable;
  logic              hit;
  logic              is_store;
  logic              fill;
  logic [3:0]        wr_be;
  logic [31:0]       word_addr;

  assign idx       = IDX'(line_index(i_addr, IDX));
  assign tag       = TAGW'(line_tag(i_addr, IDX));
  assign cacheable = (i_addr < IO_BASE);
  assign hit       = valid_q[idx] && (arr_tag == tag) && cacheable;
  assign is_store  = |i_we;
  assign word_addr = {i_addr[31:2], 2'b00};

  // RESP returns the latched bus word; otherwise present the line so a
  // hit in IDLE is visible in the same cycle.
  assign o_data = (state_q == RESP) ? resp_q : arr_data;

  dcache_array #(
    .LINES (LINES),
    .IDX   (IDX),
    .TAGW  (TAGW)
  ) u_array (
    .i_clk       (i_clk),
    .i_idx       (idx),
    .o_tag       (arr_tag),
    .o_data      (arr_data),
    .i_fill      (fill),
    .i_fill_tag  (tag),
    .i_fill_data (i_mem_data),
    .i_wr_be     (wr_be),
    .i_wr_data   (i_data)
  );

  always_comb begin
    state_d    = state_q;
    o_valid    = 1'b0;
    o_mem_req  = 1'b0;
    o_mem_addr = '0;
    o_mem_we   = '0;
    o_mem_data = '0;
    fill       = 1'b0;
    wr_be      = '0;

    case (state_q)
      IDLE: begin
        // Store wins when both strobes are set.
        if (is_store) begin
          state_d = WR_REQ;
        end else if (i_rd) begin
          if (hit) o_valid = 1'b1;
          else     state_d = RD_REQ;
        end else begin
          o_valid = 1'b1;
        end
      end
      RD_REQ: begin
        o_mem_req  = 1'b1;
        o_mem_addr = word_addr;
        if (i_mem_ack) begin
          fill    = cacheable;
          state_d = RESP;
        end
      end
      WR_REQ: begin
        o_mem_req  = 1'b1;
        o_mem_addr = word_addr;
        o_mem_we   = i_we;
        o_mem_data = i_data;
        if (i_mem_ack) begin
          // Write-through: only update a resident line, never allocate.
          if (hit) wr_be = i_we;
          state_d = RESP;
        end
      end
      RESP: begin
        o_valid = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset abandons any bus request and stalls the core.
    if (!i_rst_n) begin
      o_valid    = 1'b0;
      o_mem_req  = 1'b0;
      o_mem_addr = '0;
      o_mem_we   = '0;
      o_mem_data = '0;
      fill       = 1'b0;
      wr_be      = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      valid_q <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == RD_REQ && i_mem_ack) resp_q <= i_mem_data;
      if (fill) valid_q[idx] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed scenarios plus randomized traffic
// checked against a behavioural cache model (word address per line).
module tb_dcache;

  localparam int LINES = 64;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_addr = '0;
  logic [3:0]  i_we = '0;
  logic        i_rd = 1'b0;
  logic [31:0] i_data = '0;
  logic [31:0] o_data;
  logic        o_valid;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_we;
  logic [31:0] o_mem_data;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_data = '0;

  int checks = 0;
  int errors = 0;

  // Model: which word address each line holds, its data, and whether valid.
  bit          m_vld  [LINES];
  logic [31:0] m_word [LINES];
  logic [31:0] m_data [LINES];

  dcache dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_addr     (i_addr),
    .i_we       (i_we),
    .i_rd       (i_rd),
    .i_data     (i_data),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_mem_req  (o_mem_req),
    .o_mem_addr (o_mem_addr),
    .o_mem_we   (o_mem_we),
    .o_mem_data (o_mem_data),
    .i_mem_ack  (i_mem_ack),
    .i_mem_data (i_mem_data)
  );

  always #5 i_clk = ~i_clk;

  // Present one CPU access and run it to completion. The bus acks on the
  // ack_at-th cycle that o_mem_req is seen high. Called just after a posedge.
  task automatic do_access(input logic [31:0] a, input logic [3:0] we, input logic rd,
                           input logic [31:0] wd, input int ack_at, input logic [31:0] rdata,
                           output int lowc, output int reqc, output logic [31:0] dout,
                           output logic [31:0] maddr, output logic [3:0] mwe,
                           output logic [31:0] mdata, output bit steady, output bit timeout);
    lowc = 0; reqc = 0; dout = '0; maddr = '0; mwe = '0; mdata = '0;
    steady = 1'b1; timeout = 1'b1;
    i_addr = a; i_we = we; i_rd = rd; i_data = wd;
    for (int c = 0; c < 64; c++) begin
      #1;
      i_mem_ack  = o_mem_req && (reqc + 1 == ack_at);
      i_mem_data = i_mem_ack ? rdata : ~rdata;
      @(negedge i_clk);
      if (o_valid) begin
        dout = o_data;
        timeout = 1'b0;
        break;
      end
      lowc++;
      if (o_mem_req) begin
        if (reqc == 0) begin
          maddr = o_mem_addr; mwe = o_mem_we; mdata = o_mem_data;
        end else if (o_mem_addr !== maddr || o_mem_we !== mwe || o_mem_data !== mdata) begin
          steady = 1'b0;
        end
        reqc++;
      end else if (o_mem_addr !== 32'h0 || o_mem_we !== 4'h0 || o_mem_data !== 32'h0) begin
        steady = 1'b0;
      end
      @(posedge i_clk); #1;
      i_mem_ack = 1'b0;
    end
    @(posedge i_clk); #1;
    i_mem_ack = 1'b0; i_rd = 1'b0; i_we = 4'h0;
  endtask

  task automatic apply_reset();
    i_rst_n = 1'b0; i_rd = 1'b0; i_we = 4'h0; i_mem_ack = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    for (int i = 0; i < LINES; i++) m_vld[i] = 1'b0;
  endtask

  task automatic test_reset();
    int lc, rc; logic [31:0] d, ma, md; logic [3:0] mw; bit st, to;
    i_rst_n = 1'b0;
    @(negedge i_clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", o_valid); end
    checks++; if (o_mem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", o_mem_req); end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL idle_valid got %b want 1", o_valid); end
    checks++; if (o_mem_req !== 1'b0 || o_mem_addr !== 32'h0) begin
      errors++; $display("FAIL idle_bus got req=%b addr=%h want 0/0", o_mem_req, o_mem_addr);
    end
    @(posedge i_clk); #1;
    do_access(32'h0000_0040, 4'h0, 1'b1, 32'h0, 1, 32'h1111_2222, lc, rc, d, ma, mw, md, st, to);
    checks++; if (rc !== 1 || ma !== 32'h0000_0040 || mw !== 4'h0) begin
      errors++; $display("FAIL first_miss got req=%0d addr=%h we=%h want 1/00000040/0", rc, ma, mw);
    end
    checks++; if (lc !== 2 || d !== 32'h1111_2222 || to) begin
      errors++; $display("FAIL first_miss_resp got low=%0d data=%h to=%b want 2/11112222/0", lc, d, to);
    end
  endtask

  task automatic test_load_miss_fill();
    int lc, rc; logic [31:0] d, ma, md; logic [3:0] mw; bit st, to;
    do_access(32'h0000_0100, 4'h0, 1'b1, 32'h0, 2, 32'hDEAD_BEEF, lc, rc, d, ma, mw, md, st, to);
    checks++; if (lc !== 3 || rc !== 2 || !st) begin
      errors++; $display("FAIL miss_timing got low=%0d req=%0d steady=%b want 3/2/1", lc, rc, st);
    end
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL miss_data got %h want deadbeef", d); end
    do_access(32'h0000_0100, 4'h0, 1'b1, 32'h0, 1, 32'h0, lc, rc, d, ma, mw, md, st, to);
    checks++; if (lc !== 0 || rc !== 0 || d !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL reload_hit got low=%0d req=%0d data=%h want 0/0/deadbeef", lc, rc, d);
    end
  endtask

  task automatic test_store_merge();
    int lc, rc; logic [31:0] d, ma, md; logic [3:0] mw; bit st, to;
    do_access(32'h0000_0100, 4'b0010, 1'b0, 32'h0000_AA00, 1, 32'h0, lc, rc, d, ma, mw, md, st, to);
    checks++; if (rc !== 1 || mw !== 4'b0010 || md !== 32'h0000_AA00 || ma !== 32'h0000_0100 || lc !== 2) begin
      errors++; $display("FAIL store_bus got req=%0d we=%b data=%h addr=%h low=%0d", rc, mw, md, ma, lc);
    end
    do_access(32'h0000_0100, 4'h0, 1'b1, 32'h0, 1, 32'h0, lc, rc, d, ma, mw, md, st, to);
    checks++; if (lc !== 0 || rc !== 0 || d !== 32'hDEAD_AAEF) begin
      errors++; $display("FAIL merged_hit got low=%0d req=%0d data=%h want 0/0/deadaaef", lc, rc, d);
    end
  endtask

  task automatic test_no_allocate();
    int lc, rc; logic [31:0] d, ma, md; logic [3:0] mw; bit st, to;
    do_access(32'h0000_0200, 4'hF, 1'b0, 32'h1234_5678, 1, 32'h0, lc, rc, d, ma, mw, md, st, to);
    checks++; if (rc !== 1 || mw !== 4'hF || md !== 32'h1234_5678) begin
      errors++; $display("FAIL store_miss got req=%0d we=%h data=%h want 1/f/12345678", rc, mw, md);
    end
    do_access(32'h0000_0200, 4'h0, 1'b1, 32'h0, 2, 32'hCAFE_F00D, lc, rc, d, ma, mw, md, st, to);
    checks++; if (rc !== 2 || d !== 32'hCAFE_F00D || mw !== 4'h0) begin
      errors++; $display("FAIL no_alloc got req=%0d data=%h we=%h want 2/cafef00d/0", rc, d, mw);
    end
  endtask

  task automatic test_uncached();
    int lc, rc; logic [31:0] d, ma, md; logic [3:0] mw; bit st, to;
    do_access(32'h8000_0004, 4'h0, 1'b1, 32'h0, 3, 32'hA5A5_0001, lc, rc, d, ma, mw, md, st, to);
    checks++; if (rc !== 3 || lc !== 4 || d !== 32'hA5A5_0001 || ma !== 32'h8000_0004) begin
      errors++; $display("FAIL mmio_1 got req=%0d low=%0d data=%h addr=%h", rc, lc, d, ma);
    end
    do_access(32'h8000_0004, 4'h0, 1'b1, 32'h0, 1, 32'hA5A5_0002, lc, rc, d, ma, mw, md, st, to);
    checks++; if (rc !== 1 || lc !== 2 || d !== 32'hA5A5_0002) begin
      errors++; $display("FAIL mmio_2 got req=%0d low=%0d data=%h want 1/2/a5a50002", rc, lc, d);
    end
    checks++; if (dut.valid_q[1] !== 1'b0) begin
      errors++; $display("FAIL mmio_valid got %b want 0", dut.valid_q[1]);
    end
  endtask

  task automatic test_reset_midreq();
    int lc, rc; logic [31:0] d, ma, md; logic [3:0] mw; bit st, to;
    i_addr = 32'h0000_0100; i_rd = 1'b1; i_we = 4'h0; i_mem_ack = 1'b0;
    // Line was filled earlier; force a miss by using a different tag at the same index.
    i_addr = 32'h0000_1100;
    @(negedge i_clk);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    checks++; if (o_mem_req !== 1'b1) begin errors++; $display("FAIL midreq_req got %b want 1", o_mem_req); end
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    @(negedge i_clk);
    checks++; if (o_mem_req !== 1'b0 || o_valid !== 1'b0) begin
      errors++; $display("FAIL midreq_drop got req=%b valid=%b want 0/0", o_mem_req, o_valid);
    end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    do_access(32'h0000_1100, 4'h0, 1'b1, 32'h0, 1, 32'h0BAD_F00D, lc, rc, d, ma, mw, md, st, to);
    checks++; if (rc !== 1 || d !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL after_rst_miss got req=%0d data=%h want 1/0badf00d", rc, d);
    end
    do_access(32'h0000_0040, 4'h0, 1'b1, 32'h0, 1, 32'h7777_0040, lc, rc, d, ma, mw, md, st, to);
    checks++; if (rc !== 1 || d !== 32'h7777_0040) begin
      errors++; $display("FAIL rst_clears_valid got req=%0d data=%h want 1/77770040", rc, d);
    end
  endtask

  task automatic test_random();
    int lc, rc, ack, idx, kind; logic [31:0] a, wd, rdata, d, ma, md, word; logic [3:0] we, mw;
    bit st, to, cache, hit, rd;
    apply_reset();
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        i_mem_ack = 1'b1; i_mem_data = $urandom;   // stray ack in IDLE is ignored
        @(posedge i_clk); #1;
        i_mem_ack = 1'b0;
      end
      if ($urandom_range(0, 7) == 0)
        a = 32'h8000_0000 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
      else
        a = 32'($urandom_range(0, 2)) * (LINES * 4) + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
      kind  = $urandom_range(0, 9);
      we    = (kind < 4) ? 4'($urandom_range(1, 15)) : 4'h0;
      rd    = (kind >= 4 && kind < 9) || (kind == 0);
      wd    = $urandom;
      rdata = $urandom;
      ack   = $urandom_range(1, 4);
      word  = a & 32'hFFFF_FFFC;
      idx   = (a / 4) % LINES;
      cache = (a < 32'h8000_0000);
      hit   = cache && m_vld[idx] && (m_word[idx] == word);
      do_access(a, we, rd, wd, ack, rdata, lc, rc, d, ma, mw, md, st, to);
      checks++; if (to || !st) begin
        errors++; $display("FAIL rnd_proto n=%0d timeout=%b steady=%b", n, to, st);
      end
      if (we != 4'h0) begin
        checks++; if (lc !== ack + 1 || rc !== ack || ma !== word || mw !== we || md !== wd) begin
          errors++; $display("FAIL rnd_store n=%0d got low=%0d req=%0d addr=%h we=%h data=%h want %0d/%0d/%h/%h/%h",
                             n, lc, rc, ma, mw, md, ack + 1, ack, word, we, wd);
        end
        if (hit) for (int b = 0; b < 4; b++) if (we[b]) m_data[idx][8*b +: 8] = wd[8*b +: 8];
      end else if (rd && hit) begin
        checks++; if (lc !== 0 || rc !== 0 || d !== m_data[idx]) begin
          errors++; $display("FAIL rnd_hit n=%0d got low=%0d req=%0d data=%h want 0/0/%h", n, lc, rc, d, m_data[idx]);
        end
      end else if (rd) begin
        checks++; if (lc !== ack + 1 || rc !== ack || ma !== word || mw !== 4'h0 || d !== rdata) begin
          errors++; $display("FAIL rnd_miss n=%0d got low=%0d req=%0d addr=%h we=%h data=%h want %0d/%0d/%h/0/%h",
                             n, lc, rc, ma, mw, d, ack + 1, ack, word, rdata);
        end
        if (cache) begin m_vld[idx] = 1'b1; m_word[idx] = word; m_data[idx] = rdata; end
      end else begin
        checks++; if (lc !== 0 || rc !== 0) begin
          errors++; $display("FAIL rnd_idle n=%0d got low=%0d req=%0d want 0/0", n, lc, rc);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_miss_fill();
    test_store_merge();
    test_no_allocate();
    test_uncached();
    test_reset_midreq();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
